vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter VIDEO_WIDTH, default 3: bits per colour channel.
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal active, front porch, sync and back porch, in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical active, front porch, sync and back porch, in lines.
REQ-004 SHALL have parameters H_POL 0 and V_POL 0: sync asserted level (0 = active-low).
REQ-005 SHALL have parameter PIPE_DELAY, default 2, range 0..7: cycles from request coordinates to matching pixel data on the video inputs.
REQ-006 SHALL have parameter CW, default 10: counter and coordinate width.
REQ-007 i_Clk  in  1  single clock; all logic on its rising edge.
REQ-008 i_Rst  in  1  synchronous, active-high reset.
REQ-009 i_En  in  1  pixel enable; all state advances only on cycles with i_En=1.
REQ-010 i_Red_Video, i_Grn_Video, i_Blu_Video  in  VIDEO_WIDTH each  pixel data, PIPE_DELAY enabled cycles after its request.
REQ-011 o_Req_Col, o_Req_Row  out  CW each  current counter position (pixel request address).
REQ-012 o_Req_Valid  out  1  high when the request position is inside the active area.
REQ-013 o_HSync, o_VSync  out  1  sync outputs, registered, aligned to the video outputs.
REQ-014 o_DE  out  1  data-enable, aligned to the video outputs.
REQ-015 o_Red_Video, o_Grn_Video, o_Blu_Video  out  VIDEO_WIDTH each  registered video, forced to 0 outside the active area.
REQ-016 o_Frame_Start  out  1  one-enabled-cycle pulse, aligned to the outputs, when output pixel (0,0) is presented.

Function
REQ-017 Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-018 Column counter SHALL count 0..H_TOTAL-1, incrementing on each enabled cycle and wrapping to 0.
REQ-019 Row counter SHALL increment only on column wrap, count 0..V_TOTAL-1 and wrap to 0.
REQ-020 o_Req_Col and o_Req_Row SHALL equal the counters combinationally.
REQ-021 o_Req_Valid SHALL be (col < H_ACTIVE) AND (row < V_ACTIVE).
REQ-022 Horizontal sync SHALL be active when H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC.
REQ-023 Vertical sync SHALL be active when V_ACTIVE+V_FP <= row < V_ACTIVE+V_FP+V_SYNC, evaluated per pixel, so VSync edges coincide with col=0.
REQ-024 Sync output level SHALL be H_POL or V_POL when active and the complement otherwise.
REQ-025 Alignment: sync, DE and frame-start status computed from the counter state at enabled cycle t SHALL appear on the outputs at enabled cycle t+PIPE_DELAY+1, via a PIPE_DELAY-deep shift register plus the output register.
REQ-026 Video: at enabled cycle t+PIPE_DELAY+1, o_*_Video SHALL be the i_*_Video sampled at enabled cycle t+PIPE_DELAY when the delayed DE is 1, else 0.
REQ-027 Frame start SHALL be tagged when col=0 and row=0; o_Frame_Start SHALL be high for exactly one enabled cycle per frame.
REQ-028 When i_En=0, counters, delay line and all outputs SHALL hold their values.
REQ-029 PIPE_DELAY=0 SHALL be legal: no shift stages, only the output register (1-cycle latency).

Reset
REQ-030 When i_Rst=1 at a clock edge, regardless of i_En: counters to 0; delay line cleared to sync-inactive, DE=0, frame-start=0.
REQ-031 During reset: o_HSync = ~H_POL, o_VSync = ~V_POL, o_DE=0, video outputs 0, o_Frame_Start=0.
REQ-032 On the first cycle after reset deassertion, o_Req_Col=0, o_Req_Row=0 and o_Req_Valid=1.
REQ-033 Reset mid-frame SHALL restart at (0,0) with no residual delayed pulses.

Verification
REQ-034 Defaults, i_En=1: HSync low for col 656..751, period 800 cycles; VSync low for rows 490..491; frame period 420000 cycles.
REQ-035 PIPE_DELAY=2, i_Red_Video = low bits of o_Req_Col delayed by 2 cycles: output red tracks column with 3-cycle sync alignment; 0 at cols 640..799.
REQ-036 i_En toggled 1/0 each cycle: timing identical to REQ-034 measured in enabled cycles, outputs stable on disabled cycles.
REQ-037 Reset asserted at row 300, col 123: next cycle Req=(0,0); outputs inactive/0 for PIPE_DELAY+1 cycles; o_Frame_Start then pulses once.
REQ-038 H_POL=1, V_POL=1, PIPE_DELAY=0: sync pulses high, outputs lag counters by exactly 1 cycle.
REQ-039 Small parameters (H 4/1/1/1, V 3/1/1/1): full wrap traced cycle-by-cycle; one o_Frame_Start per 42 cycles.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel request counters, delayed sync/DE
// alignment to the video pipeline, and registered, blanked video outputs.
module vga_timing_ctrl #(
  parameter int VIDEO_WIDTH = 3,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int H_POL       = 0,
  parameter int V_POL       = 0,
  parameter int PIPE_DELAY  = 2,
  parameter int CW          = 10
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_En,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic [CW-1:0]          o_Req_Col,
  output logic [CW-1:0]          o_Req_Row,
  output logic                   o_Req_Valid,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_DE,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Frame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HPOL = 1'(H_POL);
  localparam logic VPOL = 1'(V_POL);

  // Status flags are stored as "active" bits; polarity is applied at the output
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
  } stat_t;

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  stat_t         cur;
  stat_t         tap;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      col <= '0;
      row <= '0;
    end else if (i_En) begin
      if (col == H_LAST) begin
        col <= '0;
        row <= (row == V_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign o_Req_Col   = col;
  assign o_Req_Row   = row;
  assign o_Req_Valid = (col < H_ACT) && (row < V_ACT);

  always_comb begin
    cur    = '0;
    cur.hs = (col >= HS_BEG) && (col < HS_END);
    cur.vs = (row >= VS_BEG) && (row < VS_END);
    cur.de = o_Req_Valid;
    cur.fs = (col == '0) && (row == '0);
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign tap = cur;
    end else begin : g_dly
      stat_t dly [PIPE_DELAY];

      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          for (int i = 0; i < PIPE_DELAY; i++)
            dly[i] <= '0;
        end else if (i_En) begin
          dly[0] <= cur;
          for (int i = 1; i < PIPE_DELAY; i++)
            dly[i] <= dly[i-1];
        end
      end

      assign tap = dly[PIPE_DELAY-1];
    end
  endgenerate

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_HSync       <= ~HPOL;
      o_VSync       <= ~VPOL;
      o_DE          <= 1'b0;
      o_Red_Video   <= '0;
      o_Grn_Video   <= '0;
      o_Blu_Video   <= '0;
      o_Frame_Start <= 1'b0;
    end else if (i_En) begin
      o_HSync       <= tap.hs ? HPOL : ~HPOL;
      o_VSync       <= tap.vs ? VPOL : ~VPOL;
      o_DE          <= tap.de;
      o_Red_Video   <= tap.de ? i_Red_Video : '0;
      o_Grn_Video   <= tap.de ? i_Grn_Video : '0;
      o_Blu_Video   <= tap.de ? i_Blu_Video : '0;
      o_Frame_Start <= tap.fs;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a small-raster instance driven from a vector
// table, and a default instance checked against a per-cycle raster model.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Small raster: 7x6 total, PIPE_DELAY=0, active-high syncs
  logic       s_rst, s_en;
  logic [2:0] s_red, s_grn, s_blu;
  logic [9:0] s_col, s_row;
  logic       s_valid, s_hs, s_vs, s_de, s_fs;
  logic [2:0] s_ored, s_ogrn, s_oblu;

  vga_timing_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .PIPE_DELAY(0)
  ) u_small (
    .i_Clk(clk), .i_Rst(s_rst), .i_En(s_en),
    .i_Red_Video(s_red), .i_Grn_Video(s_grn), .i_Blu_Video(s_blu),
    .o_Req_Col(s_col), .o_Req_Row(s_row), .o_Req_Valid(s_valid),
    .o_HSync(s_hs), .o_VSync(s_vs), .o_DE(s_de),
    .o_Red_Video(s_ored), .o_Grn_Video(s_ogrn), .o_Blu_Video(s_oblu),
    .o_Frame_Start(s_fs)
  );

  // Default 640x480 raster, PIPE_DELAY=2, active-low syncs
  logic       b_rst, b_en;
  logic [2:0] b_red, b_grn, b_blu;
  logic [9:0] b_col, b_row;
  logic       b_valid, b_hs, b_vs, b_de, b_fs;
  logic [2:0] b_ored, b_ogrn, b_oblu;

  vga_timing_ctrl u_big (
    .i_Clk(clk), .i_Rst(b_rst), .i_En(b_en),
    .i_Red_Video(b_red), .i_Grn_Video(b_grn), .i_Blu_Video(b_blu),
    .o_Req_Col(b_col), .o_Req_Row(b_row), .o_Req_Valid(b_valid),
    .o_HSync(b_hs), .o_VSync(b_vs), .o_DE(b_de),
    .o_Red_Video(b_ored), .o_Grn_Video(b_ogrn), .o_Blu_Video(b_oblu),
    .o_Frame_Start(b_fs)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] red;
    logic [9:0] col;
    logic [9:0] row;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] ored;
    logic       fs;
  } vec_t;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic       valid;
    logic       hs;
    logic       vs;
    logic       de;
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
    logic       fs;
  } obs_t;

  function automatic vec_t mk(int rst, int en, int red, int col, int row,
                              int valid, int hs, int vs, int de,
                              int ored, int fs);
    vec_t v;
    v.rst   = rst[0];
    v.en    = en[0];
    v.red   = red[2:0];
    v.col   = col[9:0];
    v.row   = row[9:0];
    v.valid = valid[0];
    v.hs    = hs[0];
    v.vs    = vs[0];
    v.de    = de[0];
    v.ored  = ored[2:0];
    v.fs    = fs[0];
    return v;
  endfunction

  // Raster model for the default instance after k enabled edges since reset
  function automatic obs_t exp_big(int k);
    obs_t e;
    int c, r, j;
    c = k % 800;
    r = (k / 800) % 525;
    e = '0;
    e.col   = c[9:0];
    e.row   = r[9:0];
    e.valid = (c < 640) && (r < 480);
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (k >= 3) begin
      j = k - 3;
      c = j % 800;
      r = (j / 800) % 525;
      e.hs = !((c >= 656) && (c < 752));
      e.vs = !((r >= 490) && (r < 492));
      e.de = (c < 640) && (r < 480);
      if (e.de) begin
        e.r = c[2:0];
        e.g = 3'd5;
        e.b = ~c[2:0];
      end
      e.fs = (c == 0) && (r == 0);
    end
    return e;
  endfunction

  int k = 0;
  int fs_seen = 0;

  task automatic drive_big_video();
    int src;
    src = (k >= 2) ? (k - 2) % 800 : 0;
    b_red = src[2:0];
    b_grn = 3'd5;
    b_blu = ~src[2:0];
  endtask

  task automatic check_big(string name);
    obs_t a, e;
    a = '{b_col, b_row, b_valid, b_hs, b_vs, b_de,
          b_ored, b_ogrn, b_oblu, b_fs};
    e = exp_big(k);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s k=%0d got=%h want=%h", name, k, a, e);
    end
  endtask

  task automatic big_run(int n, bit toggle, string name);
    for (int i = 0; i < n; i++) begin
      b_en = toggle ? ((i % 2) == 0) : 1'b1;
      drive_big_video();
      @(posedge clk);
      #1;
      if (b_en) k++;
      if (b_fs) fs_seen++;
      check_big(name);
    end
  endtask

  task automatic big_reset(logic en);
    b_rst = 1'b1;
    b_en  = en;
    @(posedge clk);
    #1;
    b_rst = 1'b0;
    k = 0;
    check_big("big_reset");
  endtask

  task automatic expect_int(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  vec_t tbl [14];

  initial begin
    int fs_cnt, vs_cnt, hs_cnt, de_cnt, fs_first, fs_second;
    logic [25:0] sa, se;

    tbl[0]  = mk(1,1,0, 0,0,1, 0,0,0,0,0);
    tbl[1]  = mk(0,1,5, 1,0,1, 0,0,1,5,1);
    tbl[2]  = mk(0,1,6, 2,0,1, 0,0,1,6,0);
    tbl[3]  = mk(0,1,7, 3,0,1, 0,0,1,7,0);
    tbl[4]  = mk(0,1,1, 4,0,0, 0,0,1,1,0);
    tbl[5]  = mk(0,1,2, 5,0,0, 0,0,0,0,0);
    tbl[6]  = mk(0,0,3, 5,0,0, 0,0,0,0,0);
    tbl[7]  = mk(0,1,3, 6,0,0, 1,0,0,0,0);
    tbl[8]  = mk(0,1,4, 0,1,1, 0,0,0,0,0);
    tbl[9]  = mk(0,1,2, 1,1,1, 0,0,1,2,0);
    tbl[10] = mk(1,0,6, 0,0,1, 0,0,0,0,0);
    tbl[11] = mk(0,0,6, 0,0,1, 0,0,0,0,0);
    tbl[12] = mk(0,1,4, 1,0,1, 0,0,1,4,1);
    tbl[13] = mk(0,1,3, 2,0,1, 0,0,1,3,0);

    s_rst = 1'b1; s_en = 1'b0;
    s_red = '0; s_grn = '0; s_blu = '0;
    b_rst = 1'b1; b_en = 1'b0;
    b_red = '0; b_grn = '0; b_blu = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      s_rst = tbl[i].rst;
      s_en  = tbl[i].en;
      s_red = tbl[i].red;
      @(posedge clk);
      #1;
      sa = {s_col, s_row, s_valid, s_hs, s_vs, s_de, s_ored, s_fs};
      se = {tbl[i].col, tbl[i].row, tbl[i].valid, tbl[i].hs,
            tbl[i].vs, tbl[i].de, tbl[i].ored, tbl[i].fs};
      vectors++;
      if (sa !== se) begin
        miscompares++;
        $display("FAIL small_vec%0d got=%h want=%h", i, sa, se);
      end
    end

    // Two full small frames: pulse counts and frame-start spacing
    fs_cnt = 0; vs_cnt = 0; hs_cnt = 0; de_cnt = 0;
    fs_first = -1; fs_second = -1;
    s_en = 1'b1;
    s_red = 3'd7;
    for (int i = 0; i < 84; i++) begin
      @(posedge clk);
      #1;
      if (s_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (s_vs) vs_cnt++;
      if (s_hs) hs_cnt++;
      if (s_de) de_cnt++;
    end
    expect_int("small_fs_count", fs_cnt, 2);
    expect_int("small_fs_first", fs_first, 40);
    expect_int("small_fs_period", fs_second - fs_first, 42);
    expect_int("small_vs_count", vs_cnt, 14);
    expect_int("small_hs_count", hs_cnt, 12);
    expect_int("small_de_count", de_cnt, 24);

    // Default raster: reset, two lines, then toggled enable
    big_reset(1'b0);
    fs_seen = 0;
    big_run(1700, 1'b0, "big_run");
    expect_int("big_fs_once", fs_seen, 1);
    big_run(1700, 1'b1, "big_toggle");

    // Advance to col 123 and reset mid-line
    big_run(773, 1'b0, "big_seek");
    expect_int("big_seek_col", int'(b_col), 123);
    big_reset(1'b1);
    fs_seen = 0;
    big_run(10, 1'b0, "big_restart");
    expect_int("big_restart_fs", fs_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
